// File: rtl/mem_stage_dmem_if.sv
// mem_stage_dmem_if: MEM-stage load/store bridge to the D-cache with stall, lane steering and load extension
module mem_stage_dmem_if (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] d_mem_address,
  output logic        d_mem_read,
  output logic        d_mem_write,
  output logic [3:0]  d_mem_byte_enable,
  output logic [31:0] d_mem_wdata,
  input  logic [31:0] d_mem_rdata,
  input  logic        d_mem_resp,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      r_state;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic [1:0]  w_off;
  logic        w_req;
  logic        w_legal;
  logic [3:0]  w_be;
  logic [31:0] w_sh;
  logic [31:0] w_ext;
  assign w_off = req_addr[1:0];
  assign w_req = req_valid & (req_read | req_write);
  // unsigned variants exist only for loads; a read wins when both strobes are set
  assign w_legal = (req_funct3[1:0] != 2'b11)
                 & ~(req_funct3[2] & (req_funct3[1] | ~req_read))
                 & ~((req_funct3[1:0] == 2'b01) & w_off[0])
                 & ~((req_funct3[1:0] == 2'b10) & (w_off != 2'b00));
  assign w_be = req_read ? 4'b1111 :
                (req_funct3[1:0] == 2'b00) ? 4'b0001 << w_off :
                (req_funct3[1:0] == 2'b01) ? 4'b0011 << w_off : 4'b1111;
  assign w_sh = d_mem_rdata >> {r_off, 3'b000};
  assign stall = ((r_state == IDLE) & w_req & w_legal) | (r_state == BUSY);
  // pick the addressed byte/half and extend it according to the latched funct3
  always_comb
    w_ext = (r_f3 == 3'b000) ? {{24{w_sh[7]}}, w_sh[7:0]} :
            (r_f3 == 3'b100) ? {24'b0, w_sh[7:0]} :
            (r_f3 == 3'b001) ? {{16{w_sh[15]}}, w_sh[15:0]} :
            (r_f3 == 3'b101) ? {16'b0, w_sh[15:0]} : d_mem_rdata;
  // access FSM: accept in IDLE, hold the cache request in BUSY, pulse done in DONE
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state           <= IDLE;
      r_off             <= 2'b00;
      r_f3              <= 3'b000;
      d_mem_address     <= 32'b0;
      d_mem_read        <= 1'b0;
      d_mem_write       <= 1'b0;
      d_mem_byte_enable <= 4'b0000;
      d_mem_wdata       <= 32'b0;
      load_data         <= 32'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          err <= w_req & ~w_legal;
          if (w_req & w_legal) begin
            d_mem_address     <= {req_addr[31:2], 2'b00};
            d_mem_read        <= req_read;
            d_mem_write       <= ~req_read;
            d_mem_byte_enable <= w_be;
            d_mem_wdata       <= req_wdata << {w_off, 3'b000};
            r_off             <= w_off;
            r_f3              <= req_funct3;
            r_state           <= BUSY;
          end
        end
        BUSY: begin
          if (d_mem_resp) begin
            if (d_mem_read) load_data <= w_ext;
            d_mem_read  <= 1'b0;
            d_mem_write <= 1'b0;
            done        <= 1'b1;
            r_state     <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_dmem_if.sv
// tb_mem_stage_dmem_if: directed checks of the MEM-stage D-cache interface
module tb_mem_stage_dmem_if;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic [31:0] d_mem_address;
  logic        d_mem_read;
  logic        d_mem_write;
  logic [3:0]  d_mem_byte_enable;
  logic [31:0] d_mem_wdata;
  logic [31:0] d_mem_rdata = 32'b0;
  logic        d_mem_resp = 1'b0;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        err;
  int n_cmp = 0;
  int n_bad = 0;
  int n_stall, n_rd, n_wr, got_done;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  mem_stage_dmem_if dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .d_mem_address(d_mem_address), .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_byte_enable(d_mem_byte_enable), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .stall(stall), .done(done), .load_data(load_data), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdv, input int n, input bit hold);
    n_stall = 0; n_rd = 0; n_wr = 0; got_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req_valid = 1'b1; req_read = rd; req_write = wr;
        req_funct3 = f3; req_addr = a; req_wdata = wd;
      end else if (!hold) req_valid = 1'b0;
      d_mem_resp = 1'b0;
      #1;
      if (stall) n_stall++;
      if (done) begin
        got_done = 1;
        break;
      end
      if (d_mem_read | d_mem_write) begin
        n_rd += int'(d_mem_read);
        n_wr += int'(d_mem_write);
        cap_addr = d_mem_address; cap_be = d_mem_byte_enable; cap_wdata = d_mem_wdata;
        if (n_rd + n_wr == n + 1) begin
          d_mem_resp = 1'b1;
          d_mem_rdata = rdv;
        end
      end
    end
    check("done_seen", got_done, 1);
  endtask
  task automatic do_err(input string tag, input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    req_valid = 1'b1; req_read = rd; req_write = wr; req_funct3 = f3; req_addr = a;
    #1;
    check({tag, "_stall"}, stall, 0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check({tag, "_err"}, err, 1);
    check({tag, "_strobes"}, {d_mem_read, d_mem_write}, 0);
    check({tag, "_stall2"}, stall, 0);
    @(negedge clk);
    #1;
    check({tag, "_err_pulse"}, err, 0);
    check({tag, "_strobes2"}, {d_mem_read, d_mem_write}, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_addr", d_mem_address, 0);
    check("rst_strobes", {d_mem_read, d_mem_write}, 0);
    check("rst_be", d_mem_byte_enable, 0);
    check("rst_wdata", d_mem_wdata, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_load", load_data, 0);
    check("rst_stall", stall, 0);
    @(negedge clk);
    rst = 1'b1;
    do_req(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 2, 0);
    check("lw_stall", n_stall, 4);
    check("lw_rd", n_rd, 3);
    check("lw_wr", n_wr, 0);
    check("lw_addr", cap_addr, 32'h100);
    check("lw_be", cap_be, 4'hF);
    check("lw_data", load_data, 32'hDEADBEEF);
    do_req(1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, 0, 0);
    check("lb_data", load_data, 32'hFFFFFF80);
    check("lb_stall", n_stall, 2);
    do_req(1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, 1, 0);
    check("lbu_data", load_data, 32'h00000080);
    check("lbu_stall", n_stall, 3);
    do_req(1, 0, 3'b001, 32'h102, 0, 32'h80FF0000, 0, 0);
    check("lh_data", load_data, 32'hFFFF80FF);
    do_req(1, 0, 3'b101, 32'h100, 0, 32'h1234F678, 0, 0);
    check("lhu_data", load_data, 32'h0000F678);
    do_req(0, 1, 3'b001, 32'h206, 32'h1234ABCD, 32'h55555555, 0, 0);
    check("sh_addr", cap_addr, 32'h204);
    check("sh_be", cap_be, 4'b1100);
    check("sh_wdata", cap_wdata, 32'hABCD0000);
    check("sh_wr", n_wr, 1);
    check("sh_rd", n_rd, 0);
    check("sh_stall", n_stall, 2);
    check("sh_load_kept", load_data, 32'h0000F678);
    do_req(0, 1, 3'b000, 32'h101, 32'h000000AB, 0, 1, 0);
    check("sb_be", cap_be, 4'b0010);
    check("sb_wdata", cap_wdata, 32'h0000AB00);
    check("sb_wr", n_wr, 2);
    do_req(0, 1, 3'b010, 32'h20C, 32'hCAFEF00D, 0, 0, 0);
    check("sw_be", cap_be, 4'hF);
    check("sw_wdata", cap_wdata, 32'hCAFEF00D);
    do_req(1, 1, 3'b010, 32'h40, 32'h1, 32'h0BADF00D, 0, 0);
    check("rw_rd", n_rd, 1);
    check("rw_wr", n_wr, 0);
    check("rw_data", load_data, 32'h0BADF00D);
    do_err("lw_mis", 1, 0, 3'b010, 32'h102);
    do_err("sb_f3", 0, 1, 3'b100, 32'h100);
    do_err("lh_mis", 1, 0, 3'b001, 32'h101);
    do_err("f3_011", 1, 0, 3'b011, 32'h100);
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("rb_busy_rd", d_mem_read, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rb_strobes", {d_mem_read, d_mem_write}, 0);
    check("rb_done", done, 0);
    check("rb_load", load_data, 0);
    @(negedge clk);
    d_mem_resp = 1'b1; d_mem_rdata = 32'h12345678;
    got_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      d_mem_resp = 1'b0;
      #1;
      if (done | d_mem_read) got_done = 1;
    end
    check("rb_no_done", got_done, 0);
    check("rb_load2", load_data, 0);
    do_req(1, 0, 3'b010, 32'h300, 0, 32'hA5A5A5A5, 1, 1);
    check("hold_rd", n_rd, 2);
    check("hold_stall", n_stall, 3);
    check("hold_data", load_data, 32'hA5A5A5A5);
    do_req(1, 0, 3'b010, 32'h304, 0, 32'h11223344, 0, 0);
    check("next_addr", cap_addr, 32'h304);
    check("next_rd", n_rd, 1);
    check("next_stall", n_stall, 2);
    check("next_data", load_data, 32'h11223344);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage_dmem_if.md
# mem_stage_dmem_if

MEM-stage data-memory interface between the pipelined RV32I datapath and the D-cache. It takes the MEM-stage load/store request: byte address, funct3, and unaligned rs2 store data. It issues a word-aligned, byte-enabled, registered request to the D-cache and holds it until `d_mem_resp`. It stalls the pipeline for the duration of the access and returns load data that is already shifted and sign- or zero-extended for the WB stage.

## Interface
Parameters:
- none (RV32, 32-bit data, 4 byte lanes fixed)

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-low reset
- `req_valid`  in  1  MEM stage holds a memory instruction this cycle
- `req_read`  in  1  instruction is a load
- `req_write`  in  1  instruction is a store
- `req_funct3`  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- `req_addr`  in  32  byte address (ALU result)
- `req_wdata`  in  32  rs2 value, unshifted
- `d_mem_address`  out  32  word-aligned address, bits [1:0] = 00
- `d_mem_read`  out  1  cache read strobe
- `d_mem_write`  out  1  cache write strobe
- `d_mem_byte_enable`  out  4  byte lanes to write (1111 for loads)
- `d_mem_wdata`  out  32  lane-shifted store data
- `d_mem_rdata`  in  32  cache read data; valid when `d_mem_resp` is 1
- `d_mem_resp`  in  1  cache completion
- `stall`  out  1  freeze all pipeline registers upstream of and including EX/MEM
- `done`  out  1  one-cycle pulse; the access completed this cycle
- `load_data`  out  32  extended load result, valid when `done` is 1
- `err`  out  1  one-cycle pulse for a misaligned access or illegal funct3

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - When `req_valid` is 1 and (`req_read` or `req_write`) is 1:
    - Request is legal: latch address, byte enable, wdata and funct3; go to BUSY.
    - Request is illegal: pulse `err` next cycle; no cache access; remain in IDLE.
  - A request is illegal when:
    - funct3 is 011, 110 or 111; or funct3 is 1xx on a store; or
    - H with `req_addr[0]` = 1; or W with `req_addr[1:0]` ≠ 00.
  - `req_read` and `req_write` both 1: treated as a read; the write is ignored.
- **BUSY**
  - `d_mem_read`/`d_mem_write` and all cache outputs are held constant.
  - On `d_mem_resp` = 1: capture the extended `d_mem_rdata` into `load_data`, drop the strobes at the same edge, go to DONE.
- **DONE**
  - `done` = 1, `stall` = 0.
  - Unconditional return to IDLE. `req_*` is ignored this cycle; it is the same instruction as before.
- Store lane rules, with `off` = `req_addr[1:0]`:
  - SB: BE = 0001 << off, wdata = `req_wdata` << 8·off.
  - SH: BE = 0011 << off, same shift.
  - SW: BE = 1111, unshifted.
- Load extraction:
  - `sh` = `d_mem_rdata` >> 8·off.
  - LB: sext(`sh[7:0]`). LBU: zext(`sh[7:0]`).
  - LH: sext(`sh[15:0]`). LHU: zext(`sh[15:0]`).
  - LW: `d_mem_rdata`.
- `load_data` holds its value until the next completed load; it is not updated on stores.
- `d_mem_resp` is ignored in IDLE and DONE.

## Timing
- Reset (`rst` = 0 at an edge):
  - State goes to IDLE.
  - `d_mem_address`, `d_mem_wdata` and `load_data` go to 0.
  - `d_mem_read`, `d_mem_write`, `done` and `err` go to 0; `d_mem_byte_enable` goes to 0000.
  - `stall` is 0 while `req_valid` is 0.
- Reset during BUSY: strobes are 0 from the next cycle; the outstanding access is abandoned and a later `d_mem_resp` is ignored.
- Cache outputs are registered. With the request accepted at edge t, the strobes are high from cycle t+1.
- `stall` is combinational and equals (IDLE & legal request) | BUSY. It is high from the accept cycle through the `d_mem_resp` cycle inclusive.
- Latency: for a response N cycles after the strobes rise (N ≥ 0, where N = 0 means `d_mem_resp` in the first BUSY cycle):
  - `stall` is high for N+2 cycles.
  - `done` rises in the cycle after `d_mem_resp`.
- `err` is asserted one cycle after the request and `stall` stays 0. The pipeline controller must squash or trap the instruction.
- No back-to-back issue: at least one IDLE cycle separates DONE from the next accept.

## Test plan
- **LW, 3-cycle response.** LW at 0x0000_0100; `d_mem_resp` on the 3rd BUSY cycle with `d_mem_rdata` = 0xDEADBEEF.
  - Cache side: `d_mem_address` = 0x100, BE = 1111, `d_mem_read` high for 3 cycles.
  - Pipeline side: `stall` high for 4 cycles; `done` with `load_data` = 0xDEADBEEF.
- **Byte loads, sign and zero extension.** `d_mem_rdata` = 0x80FF_0000.
  - LB at 0x103 → `load_data` = 0xFFFF_FF80.
  - LBU at 0x103 → 0x0000_0080.
  - LH at 0x102 → 0xFFFF_80FF.
- **SH, zero-wait response.** SH at 0x206 with `req_wdata` = 0x1234_ABCD; `d_mem_resp` in the first BUSY cycle.
  - Cache side: `d_mem_address` = 0x204, BE = 1100, `d_mem_wdata` = 0xABCD_0000, write high for 1 cycle.
  - Pipeline side: `stall` high for 2 cycles; `load_data` unchanged.
- **Misaligned and illegal requests.**
  - LW at 0x102 → `err` pulse, no strobes, `stall` 0.
  - SB with funct3 100 → `err` pulse.
- **Reset during BUSY.** Drive `rst` = 0 during BUSY.
  - Next cycle: strobes 0, `done` 0, `load_data` 0.
  - A `d_mem_resp` pulse two cycles later produces no `done`.
- **No double issue.** Hold `req_valid` with the same LW through DONE.
  - Exactly one cache access occurs.
  - A new request presented the cycle after DONE is accepted normally.
